// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared bus layouts, size encodings and state type for the
//               memory-access pipeline stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Pipeline bus widths
  localparam int EM_W = 107;
  localparam int MW_W = 70;

  // EXE/MEM bus field positions
  localparam int EM_WEN       = 106;
  localparam int EM_WDEST_LSB = 101;
  localparam int EM_LD        = 100;
  localparam int EM_ST        = 99;
  localparam int EM_SIZE_LSB  = 97;
  localparam int EM_SGN       = 96;
  localparam int EM_SD_LSB    = 64;
  localparam int EM_ALU_LSB   = 32;
  localparam int EM_PC_LSB    = 0;

  // Access size encodings (2'b11 behaves as a word)
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_HOLD   = 2'd2
  } mem_state_e;

  // Assemble a MEM/WB bus word
  function automatic logic [MW_W-1:0] pack_wb(input logic        wen,
                                              input logic [4:0]  wdest,
                                              input logic [31:0] result,
                                              input logic [31:0] pc);
    return {wen, wdest, result, pc};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_align
// Description : Byte-lane helper: store enables/replication, load lane
//               extraction with sign/zero extension, misalignment detect.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        sgn_i,
  input  logic [31:0] sd_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  we_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        misalign_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store lane enables, data replication and alignment check
  always_comb begin
    we_o       = 4'b1111;
    wdata_o    = sd_i;
    misalign_o = (addr_lo_i != 2'b00);
    case (size_i)
      SZ_BYTE: begin
        we_o       = 4'b0001 << addr_lo_i;
        wdata_o    = {4{sd_i[7:0]}};
        misalign_o = 1'b0;
      end
      SZ_HALF: begin
        we_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{sd_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      SZ_WORD, 2'b11: begin
        we_o       = 4'b1111;
        wdata_o    = sd_i;
        misalign_o = (addr_lo_i != 2'b00);
      end
    endcase
  end

  // Load lane selection and extension
  always_comb begin
    case (addr_lo_i)
      2'd0:    w_byte = rdata_i[7:0];
      2'd1:    w_byte = rdata_i[15:8];
      2'd2:    w_byte = rdata_i[23:16];
      default: w_byte = rdata_i[31:24];
    endcase
    w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_BYTE: ldata_o = {{24{sgn_i & w_byte[7]}}, w_byte};
      SZ_HALF: ldata_o = {{16{sgn_i & w_half[15]}}, w_half};
      default: ldata_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage. Issues load/store requests on a
//               req/ack data-memory port with access timeout, and presents a
//               registered MEM/WB bus to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            EXE_valid,
  input  logic [EM_W-1:0] EXE_MEM_bus_r,
  output logic            MEM_allow_in,
  output logic            dm_req,
  output logic [3:0]      dm_we,
  output logic [31:0]     dm_addr,
  output logic [31:0]     dm_wdata,
  input  logic            dm_ack,
  input  logic [31:0]     dm_rdata,
  input  logic            WB_allow_in,
  output logic            WB_valid,
  output logic [MW_W-1:0] MEM_WB_bus_r,
  output logic [4:0]      mem_wdest,
  output logic            mem_exc
);

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

  mem_state_e       state_q, state_d;
  logic             wen_q, wen_d;
  logic [4:0]       wdest_q, wdest_d;
  logic             ld_q, ld_d;
  logic [1:0]       size_q, size_d;
  logic             sgn_q, sgn_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dm_req_q, dm_req_d;
  logic [3:0]       dm_we_q, dm_we_d;
  logic [31:0]      dm_wdata_q, dm_wdata_d;
  logic [MW_W-1:0]  hold_q, hold_d;
  logic             wb_valid_q, wb_valid_d;
  logic [MW_W-1:0]  wb_bus_q, wb_bus_d;
  logic             exc_q, exc_d;

  // Incoming instruction fields
  logic        w_in_wen, w_in_ld, w_in_st, w_in_sgn;
  logic [4:0]  w_in_wdest;
  logic [1:0]  w_in_size;
  logic [31:0] w_in_sd, w_in_alu, w_in_pc;

  assign w_in_wen   = EXE_MEM_bus_r[EM_WEN];
  assign w_in_wdest = EXE_MEM_bus_r[EM_WDEST_LSB +: 5];
  assign w_in_ld    = EXE_MEM_bus_r[EM_LD];
  assign w_in_st    = EXE_MEM_bus_r[EM_ST];
  assign w_in_size  = EXE_MEM_bus_r[EM_SIZE_LSB +: 2];
  assign w_in_sgn   = EXE_MEM_bus_r[EM_SGN];
  assign w_in_sd    = EXE_MEM_bus_r[EM_SD_LSB +: 32];
  assign w_in_alu   = EXE_MEM_bus_r[EM_ALU_LSB +: 32];
  assign w_in_pc    = EXE_MEM_bus_r[EM_PC_LSB +: 32];

  logic w_slot_free, w_accept;
  assign w_slot_free  = !wb_valid_q || WB_allow_in;
  assign MEM_allow_in = (state_q == ST_IDLE) && w_slot_free;
  assign w_accept     = EXE_valid && MEM_allow_in;

  // The lane helper looks at the incoming instruction while idle (to check
  // alignment and build store lanes) and at the latched access otherwise
  // (to extract load data when the ack arrives).
  logic [1:0]  w_a_addr, w_a_size;
  logic        w_a_sgn, w_misalign;
  logic [3:0]  w_we;
  logic [31:0] w_wdata, w_ldata;

  assign w_a_addr = (state_q == ST_IDLE) ? w_in_alu[1:0] : addr_q[1:0];
  assign w_a_size = (state_q == ST_IDLE) ? w_in_size     : size_q;
  assign w_a_sgn  = (state_q == ST_IDLE) ? w_in_sgn      : sgn_q;

  mem_align u_align (
    .addr_lo_i  (w_a_addr),
    .size_i     (w_a_size),
    .sgn_i      (w_a_sgn),
    .sd_i       (w_in_sd),
    .rdata_i    (dm_rdata),
    .we_o       (w_we),
    .wdata_o    (w_wdata),
    .ldata_o    (w_ldata),
    .misalign_o (w_misalign)
  );

  logic            w_wr;
  logic [MW_W-1:0] w_wr_bus, w_res;

  // Next-state, access sequencing and output-slot write selection
  always_comb begin
    state_d    = state_q;
    wen_d      = wen_q;
    wdest_d    = wdest_q;
    ld_d       = ld_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_wdata_d = dm_wdata_q;
    hold_d     = hold_q;
    exc_d      = 1'b0;
    w_wr       = 1'b0;
    w_wr_bus   = '0;
    w_res      = '0;

    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_in_ld && !w_in_st) begin
            w_wr     = 1'b1;
            w_wr_bus = pack_wb(w_in_wen, w_in_wdest, w_in_alu, w_in_pc);
          end else if (w_misalign) begin
            w_wr     = 1'b1;
            w_wr_bus = pack_wb(1'b0, w_in_wdest, w_in_alu, w_in_pc);
            exc_d    = 1'b1;
          end else begin
            wen_d      = w_in_wen;
            wdest_d    = w_in_wdest;
            ld_d       = w_in_ld;
            size_d     = w_in_size;
            sgn_d      = w_in_sgn;
            addr_d     = w_in_alu;
            pc_d       = w_in_pc;
            cnt_d      = '0;
            dm_req_d   = 1'b1;
            dm_we_d    = w_in_ld ? 4'b0000 : w_we;
            dm_wdata_d = w_wdata;
            state_d    = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        // An ack on the timeout cycle still completes the access normally
        if (dm_ack || (cnt_q == CNT_LIMIT)) begin
          dm_req_d = 1'b0;
          dm_we_d  = 4'b0000;
          if (dm_ack) begin
            w_res = ld_q ? pack_wb(wen_q, wdest_q, w_ldata, pc_q)
                         : pack_wb(1'b0, wdest_q, addr_q, pc_q);
          end else begin
            w_res = pack_wb(1'b0, wdest_q, addr_q, pc_q);
            exc_d = 1'b1;
          end
          if (w_slot_free) begin
            w_wr     = 1'b1;
            w_wr_bus = w_res;
            state_d  = ST_IDLE;
          end else begin
            hold_d  = w_res;
            state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_slot_free) begin
          w_wr     = 1'b1;
          w_wr_bus = hold_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    wb_valid_d = w_wr || (wb_valid_q && !WB_allow_in);
    wb_bus_d   = w_wr ? w_wr_bus : wb_bus_q;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      wen_q      <= 1'b0;
      wdest_q    <= 5'd0;
      ld_q       <= 1'b0;
      size_q     <= 2'b00;
      sgn_q      <= 1'b0;
      addr_q     <= 32'd0;
      pc_q       <= 32'd0;
      cnt_q      <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 4'b0000;
      dm_wdata_q <= 32'd0;
      hold_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_bus_q   <= '0;
      exc_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wen_q      <= wen_d;
      wdest_q    <= wdest_d;
      ld_q       <= ld_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      addr_q     <= addr_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_wdata_q <= dm_wdata_d;
      hold_q     <= hold_d;
      wb_valid_q <= wb_valid_d;
      wb_bus_q   <= wb_bus_d;
      exc_q      <= exc_d;
    end
  end

  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_addr      = {addr_q[31:2], 2'b00};
  assign dm_wdata     = dm_wdata_q;
  assign WB_valid     = wb_valid_q;
  assign MEM_WB_bus_r = wb_bus_q;
  assign mem_exc      = exc_q;
  assign mem_wdest    = ((state_q != ST_IDLE) && wen_q) ? wdest_q : 5'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard bench for mem_stage with a word-array memory
//               responder and a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  localparam int TIMEOUT = 16;
  localparam int NOACK   = -1;  // responder never acks: access must time out
  localparam int RSTCUT  = -2;  // responder never acks: reset cuts the access

  logic         clk = 1'b0;
  logic         resetn;
  logic         EXE_valid;
  logic [106:0] EXE_MEM_bus_r;
  logic         MEM_allow_in;
  logic         dm_req;
  logic [3:0]   dm_we;
  logic [31:0]  dm_addr;
  logic [31:0]  dm_wdata;
  logic         dm_ack;
  logic [31:0]  dm_rdata;
  logic         WB_allow_in;
  logic         WB_valid;
  logic [69:0]  MEM_WB_bus_r;
  logic [4:0]   mem_wdest;
  logic         mem_exc;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .resetn        (resetn),
    .EXE_valid     (EXE_valid),
    .EXE_MEM_bus_r (EXE_MEM_bus_r),
    .MEM_allow_in  (MEM_allow_in),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .dm_ack        (dm_ack),
    .dm_rdata      (dm_rdata),
    .WB_allow_in   (WB_allow_in),
    .WB_valid      (WB_valid),
    .MEM_WB_bus_r  (MEM_WB_bus_r),
    .mem_wdest     (mem_wdest),
    .mem_exc       (mem_exc)
  );

  typedef struct {
    int          delay;
    logic [31:0] waddr;
    logic        st;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [4:0]  wd;
  } req_t;

  req_t        rq[$];
  logic [69:0] exp_q[$];
  logic [31:0] ref_mem[64];
  logic [31:0] rsp_mem[64];
  int          tests = 0;
  int          fails = 0;
  int          exc_exp = 0;
  int          exc_seen = 0;
  bit          wb_rand = 1'b1;

  task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Loaded value from arithmetic on the whole word: shift, truncate, extend
  function automatic logic [31:0] ref_load(input logic [31:0] word, input int off,
                                           input int nb, input bit sgn);
    longint v, m;
    v = longint'(word) >> (8 * off);
    if (nb < 4) begin
      m = longint'(1) << (8 * nb);
      v = v % m;
      if (sgn && v >= m / 2) v = v - m;
    end
    return v[31:0];
  endfunction

  // Drive one instruction, wait for acceptance, record expectations
  task automatic issue(input logic wen, input logic [4:0] wd, input logic ld,
                       input logic st, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] sd, input logic [31:0] alu,
                       input logic [31:0] pc, input int delay);
    int   nb, off, n, idx;
    req_t r;
    nb  = nbytes(sz);
    off = int'(alu[1:0]);
    idx = int'(alu[7:2]);
    @(negedge clk); #2;
    EXE_valid     = 1'b1;
    EXE_MEM_bus_r = {wen, wd, ld, st, sz, sgn, sd, alu, pc};
    n = 0;
    while (!MEM_allow_in && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    if (!MEM_allow_in) begin
      tests++; fails++;
      $display("FAIL accept_wait actual=stalled required=accept pc=%h", pc);
      EXE_valid = 1'b0;
      return;
    end
    if (!ld && !st) begin
      exp_q.push_back({wen, wd, alu, pc});
    end else if (off % nb != 0) begin
      exp_q.push_back({1'b0, wd, alu, pc});
      exc_exp++;
    end else begin
      r.delay = delay;
      r.waddr = {alu[31:2], 2'b00};
      r.st    = !ld;
      r.we    = ld ? 4'b0000 : 4'(((1 << nb) - 1) << off);
      r.wdata = (nb == 1) ? sd[7:0] * 32'h0101_0101 :
                (nb == 2) ? sd[15:0] * 32'h0001_0001 : sd;
      r.wd    = wen ? wd : 5'd0;
      rq.push_back(r);
      if (delay == NOACK) begin
        exp_q.push_back({1'b0, wd, alu, pc});
        exc_exp++;
      end else if (delay != RSTCUT) begin
        if (ld) begin
          exp_q.push_back({wen, wd, ref_load(ref_mem[idx], off, nb, sgn), pc});
        end else begin
          exp_q.push_back({1'b0, wd, alu, pc});
          for (int k = 0; k < nb; k++) ref_mem[idx][8*(off+k) +: 8] = sd[8*k +: 8];
        end
      end
    end
    @(posedge clk); #1;
    EXE_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rq.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || rq.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain actual=%0d_pending required=0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Writeback backpressure
  initial begin
    WB_allow_in = 1'b1;
    forever begin
      @(negedge clk); #1;
      WB_allow_in = wb_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
  end

  // Data-memory responder
  initial begin
    req_t r;
    int   n, idx;
    dm_ack   = 1'b0;
    dm_rdata = 32'd0;
    forever begin
      @(negedge clk);
      dm_ack = 1'b0;
      if (resetn && dm_req) begin
        if (rq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_req actual=req addr=%h required=idle", dm_addr);
          n = 0;
          while (dm_req && n < 64) begin @(negedge clk); n++; end
          continue;
        end
        r = rq.pop_front();
        chk("dm_addr", dm_addr, r.waddr);
        chk("dm_we", dm_we, r.we);
        if (r.st) chk("dm_wdata", dm_wdata, r.wdata);
        chk("mem_wdest", mem_wdest, r.wd);
        chk("allow_in_busy", MEM_allow_in, 1'b0);
        if (r.delay < 0) begin
          n = 0;
          while (dm_req && n < 64) begin @(negedge clk); n++; end
          if (r.delay == NOACK) chk("timeout_len", n, TIMEOUT);
        end else begin
          repeat (r.delay) @(negedge clk);
          chk("req_held", dm_req, 1'b1);
          idx      = int'(dm_addr[7:2]);
          dm_ack   = 1'b1;
          dm_rdata = rsp_mem[idx];
          for (int b = 0; b < 4; b++)
            if (dm_we[b]) rsp_mem[idx][8*b +: 8] = dm_wdata[8*b +: 8];
        end
      end
    end
  end

  // Writeback monitor
  initial begin
    forever begin
      @(negedge clk); #3;
      if (resetn) begin
        if (mem_exc) exc_seen++;
        if (WB_valid && WB_allow_in) begin
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_wb actual=%h required=none", MEM_WB_bus_r);
          end else begin
            chk("wb_bus", MEM_WB_bus_r, exp_q.pop_front());
          end
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [31:0] alu, w;
    int          kind, dly;
    resetn        = 1'b0;
    EXE_valid     = 1'b0;
    EXE_MEM_bus_r = '0;
    for (int i = 0; i < 64; i++) begin
      w          = $urandom;
      ref_mem[i] = w;
      rsp_mem[i] = w;
    end
    repeat (3) @(negedge clk);
    chk("rst_wb_valid", WB_valid, 1'b0);
    chk("rst_wb_bus", MEM_WB_bus_r, 70'd0);
    chk("rst_dm_req", dm_req, 1'b0);
    chk("rst_dm_we", dm_we, 4'd0);
    chk("rst_mem_exc", mem_exc, 1'b0);
    resetn = 1'b1;
    #1;
    chk("allow_after_rst", MEM_allow_in, 1'b1);

    // Directed cases
    issue(1'b1, 5'd5, 1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'h1234, 32'h40, 0);
    wait_drain();
    ref_mem[0] = 32'h80FF_7F01; rsp_mem[0] = 32'h80FF_7F01;
    issue(1'b1, 5'd3, 1'b1, 1'b0, 2'b00, 1'b1, 32'd0, 32'h103, 32'h44, 3);
    wait_drain();
    ref_mem[0] = 32'hBEEF_1234; rsp_mem[0] = 32'hBEEF_1234;
    issue(1'b1, 5'd4, 1'b1, 1'b0, 2'b01, 1'b0, 32'd0, 32'h202, 32'h48, 1);
    issue(1'b1, 5'd6, 1'b0, 1'b1, 2'b00, 1'b0, 32'hAB, 32'h1, 32'h4C, 2);
    issue(1'b1, 5'd7, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'h6, 32'h50, 0);
    issue(1'b1, 5'd8, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'h108, 32'h54, NOACK);
    issue(1'b1, 5'd9, 1'b1, 1'b0, 2'b10, 1'b1, 32'd0, 32'h10C, 32'h58, TIMEOUT - 1);
    wait_drain();

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 3);
      alu  = {$urandom_range(0, 32'hFF_FFFF), 8'h00} | 32'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
      dly  = ($urandom_range(0, 15) == 0) ? NOACK : $urandom_range(0, 4);
      issue(1'($urandom), 5'($urandom), kind == 1 || kind == 2, kind == 3,
            2'($urandom), 1'($urandom), $urandom, (kind == 0) ? $urandom : alu,
            $urandom, dly);
    end
    wait_drain();

    // Reset in the middle of an access
    issue(1'b1, 5'd10, 1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'h110, 32'h60, RSTCUT);
    repeat (3) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("midrst_dm_req", dm_req, 1'b0);
    chk("midrst_wb_valid", WB_valid, 1'b0);
    chk("midrst_wdest", mem_wdest, 5'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_no_wb", WB_valid, 1'b0);

    chk("exc_count", exc_seen, exc_exp);
    chk("exp_queue_empty", exp_q.size(), 0);
    chk("req_queue_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
